stream_sink_checker: RTL and testbench

//  Downstream consumer for a DUT initiator (valid/ready) port in the generated top-level bench.

---
 rtl/stream_sink_checker.sv | 173 +++++++++++++++++
 tb/tb_stream_sink_checker.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sink_checker.sv
// rtl/stream_sink_checker.sv - self-checking stream sink with LFSR backpressure
//
// Consumes a DUT valid/ready stream, pops one beat of an expected stream for
// every accepted DUT beat, and compares the two. Backpressure is optionally
// randomised by a 16-bit Fibonacci LFSR. A run starts on i_start and ends in
// DONE after DEPTH accepted beats, or in TIMEOUT after IDLE_LIMIT consecutive
// RUN cycles without an accept.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start            one-cycle pulse, starts a run unless already running
//   i_seed             LFSR seed, low 16 bits used (zero is loaded as 1)
//   i_rand_ready       1 = gate o_ready with lfsr[0]
//   i_data/i_valid     DUT stream in; o_ready back to the DUT
//   i_exp_data/_valid  expected stream in; o_exp_ready pops it
//   o_done             DONE or TIMEOUT
//   o_pass             DONE with zero mismatches
//   o_timeout          TIMEOUT
//   o_beat_cnt         beats accepted in the current run
//   o_err_cnt          mismatches, saturating
//   o_first_err_vld    a mismatch has been recorded
//   o_first_err_idx    0-based beat index of the first mismatch

module stream_sink_checker #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int IDLE_LIMIT = 100
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [31:0]                  i_seed,
    input  logic                         i_rand_ready,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WIDTH-1:0]             i_exp_data,
    input  logic                         i_exp_valid,
    output logic                         o_exp_ready,
    output logic                         o_done,
    output logic                         o_pass,
    output logic                         o_timeout,
    output logic [$clog2(DEPTH+1)-1:0]   o_beat_cnt,
    output logic [15:0]                  o_err_cnt,
    output logic                         o_first_err_vld,
    output logic [$clog2(DEPTH+1)-1:0]   o_first_err_idx
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [15:0]        lfsr;
    logic [15:0]        lfsr_nxt;
    logic [15:0]        seed_load;
    logic [CNT_W-1:0]   beat_cnt;
    logic [15:0]        err_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               first_err_vld;
    logic [CNT_W-1:0]   first_err_idx;

    logic               running;
    logic               gate;
    logic               accept;
    logic               mismatch;
    logic               start_run;
    logic               last_beat;
    logic               idle_expire;

    // Only the low half of the seed feeds the LFSR.
    logic               unused_seed_hi;
    assign unused_seed_hi = ^i_seed[31:16];

    assign running     = (state == S_RUN);
    assign gate        = i_rand_ready ? lfsr[0] : 1'b1;
    // Ready also waits for an expected beat so the two streams stay in lockstep.
    assign o_ready     = running & i_exp_valid & gate;
    assign accept      = i_valid & o_ready;
    assign o_exp_ready = accept;
    assign mismatch    = (i_data != i_exp_data);
    assign start_run   = i_start & ~running;
    assign last_beat   = (beat_cnt == CNT_W'(DEPTH - 1));
    // True in the cycle whose idle increment would make idle_cnt == IDLE_LIMIT.
    assign idle_expire = (idle_cnt == IDLE_W'(IDLE_LIMIT - 1));

    // A zero state would lock the LFSR, so a zero seed is replaced by 1.
    assign seed_load   = (i_seed[15:0] == 16'h0000) ? 16'h0001 : i_seed[15:0];
    // x^16 + x^14 + x^13 + x^11 + 1, shift left, feedback into bit 0.
    assign lfsr_nxt    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (i_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // An accept always clears idle, so it beats a coincident timeout.
                if (accept) begin
                    if (last_beat) begin
                        state_nxt = S_DONE;
                    end
                end else if (idle_expire) begin
                    state_nxt = S_TIMEOUT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr          <= 16'h0001;
            beat_cnt      <= '0;
            err_cnt       <= '0;
            idle_cnt      <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (start_run) begin
            lfsr          <= seed_load;
            beat_cnt      <= '0;
            err_cnt       <= '0;
            idle_cnt      <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (running) begin
            lfsr <= lfsr_nxt;
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
                idle_cnt <= '0;
                if (mismatch) begin
                    if (err_cnt != 16'hFFFF) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                    if (!first_err_vld) begin
                        first_err_vld <= 1'b1;
                        first_err_idx <= beat_cnt;
                    end
                end
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign o_done          = (state == S_DONE) | (state == S_TIMEOUT);
    assign o_pass          = (state == S_DONE) & (err_cnt == 16'h0000);
    assign o_timeout       = (state == S_TIMEOUT);
    assign o_beat_cnt      = beat_cnt;
    assign o_err_cnt       = err_cnt;
    assign o_first_err_vld = first_err_vld;
    assign o_first_err_idx = first_err_idx;

endmodule

// File: tb/tb_stream_sink_checker.sv
// tb/tb_stream_sink_checker.sv - randomized bench with behavioural model for stream_sink_checker

module tb_stream_sink_checker;

    localparam int WIDTH      = 32;
    localparam int DEPTH      = 8;
    localparam int IDLE_LIMIT = 100;
    localparam int CW         = $clog2(DEPTH + 1);

    logic              i_clk        = 1'b0;
    logic              i_rst_n      = 1'b1;
    logic              i_start      = 1'b0;
    logic [31:0]       i_seed       = '0;
    logic              i_rand_ready = 1'b0;
    logic [WIDTH-1:0]  i_data       = '0;
    logic              i_valid      = 1'b0;
    logic [WIDTH-1:0]  i_exp_data   = '0;
    logic              i_exp_valid  = 1'b0;
    logic              o_ready;
    logic              o_exp_ready;
    logic              o_done;
    logic              o_pass;
    logic              o_timeout;
    logic [CW-1:0]     o_beat_cnt;
    logic [15:0]       o_err_cnt;
    logic              o_first_err_vld;
    logic [CW-1:0]     o_first_err_idx;

    stream_sink_checker #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .IDLE_LIMIT (IDLE_LIMIT)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_start         (i_start),
        .i_seed          (i_seed),
        .i_rand_ready    (i_rand_ready),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_exp_data      (i_exp_data),
        .i_exp_valid     (i_exp_valid),
        .o_exp_ready     (o_exp_ready),
        .o_done          (o_done),
        .o_pass          (o_pass),
        .o_timeout       (o_timeout),
        .o_beat_cnt      (o_beat_cnt),
        .o_err_cnt       (o_err_cnt),
        .o_first_err_vld (o_first_err_vld),
        .o_first_err_idx (o_first_err_idx)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs
    logic [WIDTH-1:0] exp_arr  [DEPTH];
    logic [WIDTH-1:0] data_arr [DEPTH];
    int v_pct     = 100;
    int ev_pct    = 100;
    bit ev_low    = 0;
    int valid_cut = DEPTH;

    // Behavioural model: run flags, counters, and the LFSR sequence
    bit          m_active, m_fin, m_to, m_fvld;
    int          m_beats, m_errs, m_idle, m_fidx;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(negedge i_clk) begin : model
        bit gate, e_ready, e_acc;
        if (!i_rst_n) begin
            m_active = 0; m_fin = 0; m_to = 0; m_fvld = 0;
            m_beats = 0; m_errs = 0; m_idle = 0; m_fidx = 0;
            m_lfsr = 16'h0001;
        end
        gate    = i_rand_ready ? m_lfsr[0] : 1'b1;
        e_ready = i_rst_n && m_active && i_exp_valid && gate;
        e_acc   = e_ready && i_valid;
        chk("ready",     o_ready,         e_ready);
        chk("exp_ready", o_exp_ready,     e_acc);
        chk("done",      o_done,          m_fin || m_to);
        chk("pass",      o_pass,          m_fin && (m_errs == 0));
        chk("timeout",   o_timeout,       m_to);
        chk("beat_cnt",  o_beat_cnt,      m_beats);
        chk("err_cnt",   o_err_cnt,       m_errs);
        chk("first_vld", o_first_err_vld, m_fvld);
        chk("first_idx", o_first_err_idx, m_fidx);
        if (i_rst_n) begin
            if (!m_active) begin
                if (i_start) begin
                    m_active = 1; m_fin = 0; m_to = 0; m_fvld = 0;
                    m_beats = 0; m_errs = 0; m_idle = 0; m_fidx = 0;
                    m_lfsr = (i_seed[15:0] == 16'h0) ? 16'h0001 : i_seed[15:0];
                end
            end else begin
                m_lfsr = lfsr_step(m_lfsr);
                if (e_acc) begin
                    if (i_data !== i_exp_data) begin
                        if (m_errs < 65535) m_errs++;
                        if (!m_fvld) begin
                            m_fvld = 1;
                            m_fidx = m_beats;
                        end
                    end
                    m_beats++;
                    m_idle = 0;
                    if (m_beats == DEPTH) begin
                        m_active = 0;
                        m_fin    = 1;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == IDLE_LIMIT) begin
                        m_active = 0;
                        m_to     = 1;
                    end
                end
            end
        end
    end

    // Present the beat the model says is next, like a memory reader would.
    task automatic drive();
        int k;
        k = (m_beats > DEPTH - 1) ? DEPTH - 1 : m_beats;
        i_exp_data  = exp_arr[k];
        i_data      = data_arr[k];
        i_valid     = (m_beats >= valid_cut) ? 1'b0 : ($urandom_range(1, 100) <= v_pct);
        i_exp_valid = ev_low ? 1'b0 : ($urandom_range(1, 100) <= ev_pct);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        drive();
    endtask

    task automatic start_run(input logic [31:0] seed, input logic rr);
        i_seed       = seed;
        i_rand_ready = rr;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    task automatic run_to_end(input int limit, input bit mid_start, output int cyc);
        cyc = 0;
        while (!o_done && cyc < limit) begin
            i_start = mid_start && (cyc == 2);
            tick();
            i_start = 1'b0;
            cyc++;
        end
        chk("run_end", o_done, 1'b1);
    endtask

    task automatic wait_beats(input int n, input int limit);
        int c;
        c = 0;
        while (m_beats < n && c < limit) begin
            tick();
            c++;
        end
        chk("wait_beats", (m_beats >= n), 1'b1);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < DEPTH; k++) begin
            exp_arr[k]  = WIDTH'(k);
            data_arr[k] = WIDTH'(k);
        end
    endtask

    bit tr_a [64];
    bit tr_b [64];
    int len_a, len_b;

    task automatic trace_run(input logic [31:0] seed, input bit which);
        int n;
        int cyc;
        n = 0;
        start_run(seed, 1'b1);
        while (!o_done && n < 64) begin
            #1;
            if (which) tr_b[n] = o_ready; else tr_a[n] = o_ready;
            n++;
            tick();
        end
        if (which) len_b = n; else len_a = n;
        run_to_end(2000, 1'b0, cyc);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  cyc;
        int  toggles;
        bit  prev;
        load_ramp();
        for (int i = 0; i < 64; i++) begin
            tr_a[i] = 0;
            tr_b[i] = 0;
        end

        // Reset state
        #1 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready",   o_ready,    1'b0);
        chk("rst_done",    o_done,     1'b0);
        chk("rst_beats",   o_beat_cnt, 0);
        chk("rst_err",     o_err_cnt,  0);
        i_rst_n = 1'b1;
        tick();

        // 1: clean ramp, no backpressure -> 8 accepts back to back
        start_run(32'h0, 1'b0);
        run_to_end(50, 1'b0, cyc);
        chk("t1_cycles", cyc, 8);
        chk("t1_pass",   o_pass, 1'b1);
        chk("t1_beats",  o_beat_cnt, 8);
        chk("t1_err",    o_err_cnt, 0);
        repeat (3) tick();
        chk("t1_hold_done",  o_done, 1'b1);
        chk("t1_hold_beats", o_beat_cnt, 8);

        // 2: corrupted beat 3
        data_arr[3] = 32'hDEAD;
        start_run(32'h0, 1'b0);
        run_to_end(50, 1'b0, cyc);
        chk("t2_err",   o_err_cnt, 1);
        chk("t2_fvld",  o_first_err_vld, 1'b1);
        chk("t2_fidx",  o_first_err_idx, 3);
        chk("t2_pass",  o_pass, 1'b0);
        chk("t2_beats", o_beat_cnt, 8);
        load_ramp();

        // Mismatch on the final beat still fails the run
        data_arr[DEPTH-1] = 32'hFFFF_0000;
        start_run(32'h0, 1'b0);
        run_to_end(50, 1'b0, cyc);
        chk("tlast_err",  o_err_cnt, 1);
        chk("tlast_fidx", o_first_err_idx, DEPTH - 1);
        chk("tlast_pass", o_pass, 1'b0);
        chk("tlast_done", o_done, 1'b1);
        load_ramp();

        // 3: valid stops after 5 beats -> timeout 100 idle cycles later
        valid_cut = 5;
        start_run(32'h0, 1'b0);
        run_to_end(300, 1'b0, cyc);
        chk("t3_cycles",  cyc, 105);
        chk("t3_timeout", o_timeout, 1'b1);
        chk("t3_beats",   o_beat_cnt, 5);
        chk("t3_pass",    o_pass, 1'b0);
        valid_cut = DEPTH;

        // 5: expected stream stalls for 10 cycles mid-run
        start_run(32'h0, 1'b0);
        wait_beats(3, 50);
        ev_low = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("t5_ready_low",     o_ready, 1'b0);
            chk("t5_exp_ready_low", o_exp_ready, 1'b0);
        end
        ev_low = 0;
        run_to_end(50, 1'b0, cyc);
        chk("t5_pass",    o_pass, 1'b1);
        chk("t5_timeout", o_timeout, 1'b0);
        chk("t5_err",     o_err_cnt, 0);

        // 4: random ready with seed ACE1, random valid
        for (int k = 0; k < DEPTH; k++) begin
            exp_arr[k]  = $urandom;
            data_arr[k] = exp_arr[k];
        end
        v_pct = 60;
        start_run(32'hACE1, 1'b1);
        toggles = 0;
        prev    = 1'b0;
        cyc     = 0;
        while (!o_done && cyc < 2000) begin
            #1;
            if (o_ready != prev) toggles++;
            prev = o_ready;
            tick();
            cyc++;
        end
        chk("t4_done",    o_done, 1'b1);
        chk("t4_pass",    o_pass, 1'b1);
        chk("t4_beats",   o_beat_cnt, 8);
        chk("t4_toggles", (toggles > 0), 1'b1);

        // 4b: seed 0 must behave exactly like seed 1
        v_pct = 100;
        trace_run(32'h1, 1'b0);
        trace_run(32'h0, 1'b1);
        chk("t4b_len", len_b, len_a);
        for (int i = 0; i < 64; i++) chk("t4b_trace", tr_b[i], tr_a[i]);
        // From state 1 the set bit walks up for 10 shifts before feedback fires.
        chk("t4b_pin0", tr_a[0], 1'b1);
        for (int i = 1; i <= 10; i++) chk("t4b_pin_zero", tr_a[i], 1'b0);
        chk("t4b_pin11", tr_a[11], 1'b1);

        // 6: reset mid-run, then a clean run
        load_ramp();
        start_run(32'h0, 1'b0);
        wait_beats(4, 50);
        i_rst_n = 1'b0;
        #1;
        chk("t6_ready_now", o_ready, 1'b0);
        chk("t6_beats_now", o_beat_cnt, 0);
        chk("t6_done_now",  o_done, 1'b0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        start_run(32'h0, 1'b0);
        run_to_end(50, 1'b0, cyc);
        chk("t6_pass",  o_pass, 1'b1);
        chk("t6_beats", o_beat_cnt, 8);

        // Random runs: mixed gating, stalls, corruption, early cut, stray starts
        for (int r = 0; r < 24; r++) begin
            logic [31:0] seed;
            logic        rr;
            bit          mid;
            rr        = 1'($urandom_range(0, 1));
            seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            v_pct     = $urandom_range(30, 100);
            ev_pct    = $urandom_range(50, 100);
            valid_cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DEPTH - 1)) : DEPTH;
            mid       = 1'($urandom_range(0, 1));
            for (int k = 0; k < DEPTH; k++) begin
                exp_arr[k]  = $urandom;
                data_arr[k] = ($urandom_range(0, 5) == 0) ? (exp_arr[k] ^ ($urandom | 32'h1)) : exp_arr[k];
            end
            start_run(seed, rr);
            run_to_end(3000, mid, cyc);
            repeat (2) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
